// File: rtl/chopsticks_ctrl.sv
// Chopsticks finger game controller: key edge detect, page FSM,
// configurable hand count, move legality, scoring and win/draw detection.
module chopsticks_ctrl #(
    parameter int MAX_HANDS  = 5,
    parameter int MIN_HANDS  = 2,
    parameter int MOD        = 10,
    parameter int DRAW_LIMIT = 2,
    localparam int CW        = $clog2(MAX_HANDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   key_up,
    input  logic                   key_left,
    input  logic                   key_right,
    input  logic                   key_down,
    input  logic                   key_space,
    output logic [1:0]             page,
    output logic [CW:0]            hands,
    output logic [8*MAX_HANDS-1:0] status,
    output logic                   cur_row,
    output logic [CW-1:0]          cur_col,
    output logic                   sel_row,
    output logic [CW-1:0]          sel_col,
    output logic                   selecting,
    output logic                   cur_player,
    output logic [3:0]             predict,
    output logic [1:0]             game_end,
    output logic [7:0]             move_cnt
);
    localparam int NC = 2 * MAX_HANDS;
    localparam int IW = $clog2(NC);

    typedef enum logic [1:0] {PG_MAIN, PG_HELP, PG_CFG, PG_GAME} page_e;

    page_e         r_page, w_page_nxt;
    logic [4:0]    r_prev, w_lvl, w_rise;
    logic          w_up, w_left, w_right, w_down, w_space;
    logic [CW:0]   r_hands;
    logic [3:0]    r_val [NC];
    logic [3:0]    w_new [NC];
    logic          r_cur_row, r_sel_row, r_selecting, r_player;
    logic [CW-1:0] r_cur_col, r_sel_col, w_last;
    logic [1:0]    r_end, w_end_nxt;
    logic [7:0]    r_mcnt;
    logic [2:0]    r_zrun, w_zrun_nxt;
    logic [IW-1:0] w_cur_cell, w_sel_cell, w_tgt_cell, w_src_cell;
    logic [3:0]    w_tgt_val, w_src_val, w_sum;
    logic          w_game, w_enter, w_mv, w_legal;
    logic          w_row0_live, w_row1_live;

    function automatic logic [3:0] mod_add(input logic [3:0] a,
                                           input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 5'(MOD)) s = s - 5'(MOD);
        return s[3:0];
    endfunction

    // One event per tick, highest-priority rising key wins
    assign w_lvl   = {key_up, key_left, key_right, key_down, key_space};
    assign w_rise  = tick ? (w_lvl & ~r_prev) : 5'd0;
    assign w_up    = w_rise[4];
    assign w_left  = w_rise[3] & ~w_rise[4];
    assign w_right = w_rise[2] & ~|w_rise[4:3];
    assign w_down  = w_rise[1] & ~|w_rise[4:2];
    assign w_space = w_rise[0] & ~|w_rise[4:1];

    always_ff @(posedge clk) begin
        if (rst) r_page <= PG_MAIN;
        else     r_page <= w_page_nxt;
    end

    always_comb begin
        w_page_nxt = r_page;
        unique case (r_page)
            PG_MAIN: begin
                if (w_up)        w_page_nxt = PG_CFG;
                else if (w_down) w_page_nxt = PG_HELP;
            end
            PG_HELP: if (w_down) w_page_nxt = PG_MAIN;
            PG_CFG: begin
                if (w_up)        w_page_nxt = PG_GAME;
                else if (w_down) w_page_nxt = PG_MAIN;
            end
            PG_GAME: if (w_space && r_end != 2'd0) w_page_nxt = PG_MAIN;
            default: w_page_nxt = PG_MAIN;
        endcase
    end

    assign w_cur_cell = IW'(r_cur_col) + (r_cur_row ? IW'(MAX_HANDS) : '0);
    assign w_sel_cell = IW'(r_sel_col) + (r_sel_row ? IW'(MAX_HANDS) : '0);
    assign w_tgt_cell = (r_sel_row == r_player) ? w_sel_cell : w_cur_cell;
    assign w_src_cell = (r_sel_row == r_player) ? w_cur_cell : w_sel_cell;
    assign w_tgt_val  = r_val[w_tgt_cell];
    assign w_src_val  = r_val[w_src_cell];
    assign w_sum      = mod_add(w_tgt_val, w_src_val);
    assign w_last     = CW'(r_hands - (CW+1)'(1));

    assign w_game  = (r_page == PG_GAME);
    assign w_enter = (r_page == PG_CFG) && w_up;
    assign w_mv    = w_game && w_space && (r_end == 2'd0) && r_selecting &&
                     (r_sel_row != r_cur_row);
    assign w_legal = w_mv && (w_tgt_val != 4'd0);

    // Win detection looks at the board as it will be after this move
    always_comb begin
        w_row0_live = 1'b0;
        w_row1_live = 1'b0;
        for (int i = 0; i < NC; i++)
            w_new[i] = (IW'(i) == w_tgt_cell) ? w_sum : r_val[i];
        for (int c = 0; c < MAX_HANDS; c++) begin
            if ((CW+1)'(c) < r_hands) begin
                if (w_new[c] != 4'd0)           w_row0_live = 1'b1;
                if (w_new[MAX_HANDS+c] != 4'd0) w_row1_live = 1'b1;
            end
        end
    end

    assign w_zrun_nxt = (w_src_val != 4'd0) ? 3'd0 :
                        (r_zrun == 3'(DRAW_LIMIT)) ? r_zrun : r_zrun + 3'd1;
    assign w_end_nxt  = !w_row0_live ? 2'd1 :
                        !w_row1_live ? 2'd2 :
                        (w_zrun_nxt == 3'(DRAW_LIMIT)) ? 2'd3 : 2'd0;

    always_ff @(posedge clk) begin
        if (rst)       r_prev <= 5'd0;
        else if (tick) r_prev <= w_lvl;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hands <= (CW+1)'(MIN_HANDS);
        end else if (r_page == PG_CFG) begin
            if (w_left && r_hands > (CW+1)'(MIN_HANDS))
                r_hands <= r_hands - (CW+1)'(1);
            else if (w_right && r_hands < (CW+1)'(MAX_HANDS))
                r_hands <= r_hands + (CW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_enter) begin
            for (int i = 0; i < NC; i++) r_val[i] <= 4'd1;
            r_cur_row   <= 1'b0;
            r_cur_col   <= '0;
            r_sel_row   <= 1'b0;
            r_sel_col   <= '0;
            r_selecting <= 1'b0;
            r_player    <= 1'b0;
            r_end       <= 2'd0;
            r_mcnt      <= 8'd0;
            r_zrun      <= 3'd0;
        end else if (w_game) begin
            if (w_up || w_down) r_cur_row <= ~r_cur_row;
            if (w_left)
                r_cur_col <= (r_cur_col == '0) ? w_last : r_cur_col - CW'(1);
            if (w_right)
                r_cur_col <= (r_cur_col == w_last) ? '0 : r_cur_col + CW'(1);
            if (w_space && r_end == 2'd0) begin
                if (!r_selecting) begin
                    r_sel_row   <= r_cur_row;
                    r_sel_col   <= r_cur_col;
                    r_selecting <= 1'b1;
                end else begin
                    r_selecting <= 1'b0;
                    if (w_legal) begin
                        r_val[w_tgt_cell] <= w_sum;
                        r_player          <= ~r_player;
                        r_zrun            <= w_zrun_nxt;
                        r_end             <= w_end_nxt;
                        if (r_mcnt != 8'hFF) r_mcnt <= r_mcnt + 8'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        page       = r_page;
        hands      = r_hands;
        cur_row    = r_cur_row;
        cur_col    = r_cur_col;
        sel_row    = r_sel_row;
        sel_col    = r_sel_col;
        selecting  = r_selecting;
        cur_player = r_player;
        game_end   = r_end;
        move_cnt   = r_mcnt;
        predict    = mod_add(r_val[w_cur_cell], r_val[w_sel_cell]);
        status     = '0;
        for (int i = 0; i < NC; i++) status[i*4 +: 4] = r_val[i];
    end
endmodule

// File: tb/tb_chopsticks_ctrl.sv
// Bench for chopsticks_ctrl: directed vector table, corner sequences and
// random keys against a behavioural game model, on MOD=10 and MOD=2 copies.
module tb_chopsticks_ctrl;
    localparam int MAXH = 5;
    localparam int MINH = 2;
    localparam int DL   = 2;

    localparam logic [4:0] K_U = 5'b10000;
    localparam logic [4:0] K_L = 5'b01000;
    localparam logic [4:0] K_R = 5'b00100;
    localparam logic [4:0] K_D = 5'b00010;
    localparam logic [4:0] K_S = 5'b00001;
    localparam logic [4:0] K_0 = 5'b00000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [4:0] keys = 5'd0;

    logic [1:0]  pg  [2];
    logic [3:0]  hd  [2];
    logic [39:0] st  [2];
    logic        crw [2];
    logic [2:0]  ccl [2];
    logic        srw [2];
    logic [2:0]  scl [2];
    logic        slg [2];
    logic        ply [2];
    logic [3:0]  prd [2];
    logic [1:0]  ge  [2];
    logic [7:0]  mcn [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        chopsticks_ctrl #(
            .MAX_HANDS(MAXH), .MIN_HANDS(MINH),
            .MOD(g == 0 ? 10 : 2), .DRAW_LIMIT(DL)
        ) u_dut (
            .clk(clk), .rst(rst), .tick(tick),
            .key_up(keys[4]), .key_left(keys[3]),
            .key_right(keys[2]), .key_down(keys[1]),
            .key_space(keys[0]),
            .page(pg[g]), .hands(hd[g]), .status(st[g]),
            .cur_row(crw[g]), .cur_col(ccl[g]),
            .sel_row(srw[g]), .sel_col(scl[g]),
            .selecting(slg[g]), .cur_player(ply[g]),
            .predict(prd[g]), .game_end(ge[g]), .move_cnt(mcn[g])
        );
    end

    int m_page [2], m_hands [2], m_cr [2], m_cc [2];
    int m_sr [2], m_sc [2], m_slg [2], m_pl [2];
    int m_end [2], m_mc [2], m_zr [2];
    int m_val [2][2][MAXH];
    bit [4:0] m_prev [2];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int k,
                       input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h want %0h", nm, k, act, exp);
        end
    endtask

    task automatic new_game(input int k);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < MAXH; c++) m_val[k][r][c] = 1;
        m_cr[k] = 0; m_cc[k] = 0; m_sr[k] = 0; m_sc[k] = 0;
        m_slg[k] = 0; m_pl[k] = 0; m_end[k] = 0;
        m_mc[k] = 0; m_zr[k] = 0;
    endtask

    function automatic bit row_dead(input int k, input int r);
        for (int c = 0; c < m_hands[k]; c++)
            if (m_val[k][r][c] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic game_key(input int k, input int ev, input int mod);
        int tr, tc, sr, sc, sv;
        if (ev == 4 || ev == 1) m_cr[k] = 1 - m_cr[k];
        else if (ev == 3) m_cc[k] = (m_cc[k] + m_hands[k] - 1) % m_hands[k];
        else if (ev == 2) m_cc[k] = (m_cc[k] + 1) % m_hands[k];
        else if (ev == 0) begin
            if (m_end[k] != 0) m_page[k] = 0;
            else if (m_slg[k] == 0) begin
                m_sr[k] = m_cr[k]; m_sc[k] = m_cc[k]; m_slg[k] = 1;
            end else if (m_sr[k] == m_cr[k]) m_slg[k] = 0;
            else begin
                m_slg[k] = 0;
                if (m_sr[k] == m_pl[k]) begin
                    tr = m_sr[k]; tc = m_sc[k]; sr = m_cr[k]; sc = m_cc[k];
                end else begin
                    tr = m_cr[k]; tc = m_cc[k]; sr = m_sr[k]; sc = m_sc[k];
                end
                if (m_val[k][tr][tc] != 0) begin
                    sv = m_val[k][sr][sc];
                    m_val[k][tr][tc] = (m_val[k][tr][tc] + sv) % mod;
                    m_zr[k] = (sv != 0) ? 0 : (m_zr[k] < DL ? m_zr[k] + 1 : DL);
                    m_pl[k] = 1 - m_pl[k];
                    if (m_mc[k] < 255) m_mc[k]++;
                    if (row_dead(k, 0))      m_end[k] = 1;
                    else if (row_dead(k, 1)) m_end[k] = 2;
                    else if (m_zr[k] == DL)  m_end[k] = 3;
                end
            end
        end
    endtask

    task automatic model_step(input int k, input bit r, input bit t,
                              input bit [4:0] kk);
        int mod, ev;
        bit [4:0] rise;
        mod = (k == 0) ? 10 : 2;
        if (r) begin
            m_page[k] = 0; m_hands[k] = MINH; m_prev[k] = 5'd0;
            new_game(k);
            return;
        end
        if (!t) return;
        rise = kk & ~m_prev[k];
        m_prev[k] = kk;
        ev = -1;
        for (int b = 4; b >= 0; b--) if (rise[b] && ev < 0) ev = b;
        case (m_page[k])
            0: if (ev == 4) m_page[k] = 2; else if (ev == 1) m_page[k] = 1;
            1: if (ev == 1) m_page[k] = 0;
            2: begin
                if (ev == 4) begin m_page[k] = 3; new_game(k); end
                else if (ev == 1) m_page[k] = 0;
                else if (ev == 3 && m_hands[k] > MINH) m_hands[k]--;
                else if (ev == 2 && m_hands[k] < MAXH) m_hands[k]++;
            end
            default: game_key(k, ev, mod);
        endcase
    endtask

    task automatic compare_model(input int k);
        logic [39:0] s;
        int mod, p;
        mod = (k == 0) ? 10 : 2;
        s = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < MAXH; c++)
                s[(r*MAXH+c)*4 +: 4] = 4'(m_val[k][r][c]);
        p = (m_val[k][m_cr[k]][m_cc[k]] + m_val[k][m_sr[k]][m_sc[k]]) % mod;
        chk("page", k, pg[k], m_page[k]);
        chk("hands", k, hd[k], m_hands[k]);
        chk("status", k, st[k], s);
        chk("cur_row", k, crw[k], m_cr[k]);
        chk("cur_col", k, ccl[k], m_cc[k]);
        chk("sel_row", k, srw[k], m_sr[k]);
        chk("sel_col", k, scl[k], m_sc[k]);
        chk("selecting", k, slg[k], m_slg[k]);
        chk("player", k, ply[k], m_pl[k]);
        chk("predict", k, prd[k], p);
        chk("game_end", k, ge[k], m_end[k]);
        chk("move_cnt", k, mcn[k], m_mc[k]);
    endtask

    task automatic apply(input bit r, input bit t, input bit [4:0] kk);
        rst = r; tick = t; keys = kk;
        @(posedge clk);
        model_step(0, r, t, kk);
        model_step(1, r, t, kk);
        #1;
        compare_model(0);
        compare_model(1);
    endtask

    task automatic press(input bit [4:0] kk);
        apply(1'b0, 1'b1, kk);
        apply(1'b0, 1'b1, K_0);
    endtask

    typedef struct {
        bit       r, t;
        bit [4:0] k;
        int       pg, h, s00, cr, cc, sl, pl, pr, mc;
    } vec_t;

    function automatic vec_t V(bit r, bit t, bit [4:0] k, int pg, int h,
                               int s00, int cr, int cc, int sl, int pl,
                               int pr, int mc);
        vec_t v;
        v.r = r; v.t = t; v.k = k; v.pg = pg; v.h = h; v.s00 = s00;
        v.cr = cr; v.cc = cc; v.sl = sl; v.pl = pl; v.pr = pr; v.mc = mc;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        vt.push_back(V(1, 0, K_0, 0, 2, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(V(0, 1, K_U, 2, 2, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(V(0, 1, K_L, 2, 2, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(V(0, 1, K_R, 2, 3, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(V(0, 1, K_R, 2, 4, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(V(0, 1, K_R, 2, 5, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(V(0, 1, K_R, 2, 5, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(V(0, 1, K_R, 2, 5, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(V(0, 1, K_L, 2, 4, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(V(0, 1, K_L, 2, 3, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(V(0, 1, K_L, 2, 2, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(V(0, 1, K_U, 3, 2, 1, 0, 0, 0, 0, 2, 0));
        vt.push_back(V(0, 1, K_S, 3, 2, 1, 0, 0, 1, 0, 2, 0));
        vt.push_back(V(0, 1, K_D, 3, 2, 1, 1, 0, 1, 0, 2, 0));
        vt.push_back(V(0, 1, K_S, 3, 2, 2, 1, 0, 0, 1, 3, 1));
        vt.push_back(V(0, 1, K_S, 3, 2, 2, 1, 0, 1, 1, 2, 1));
        vt.push_back(V(0, 1, K_R, 3, 2, 2, 1, 1, 1, 1, 2, 1));
        vt.push_back(V(0, 1, K_S, 3, 2, 2, 1, 1, 0, 1, 2, 1));
        vt.push_back(V(0, 1, K_R, 3, 2, 2, 1, 0, 0, 1, 2, 1));
        vt.push_back(V(0, 1, K_L, 3, 2, 2, 1, 1, 0, 1, 2, 1));
        vt.push_back(V(0, 1, K_U | K_S, 3, 2, 2, 0, 1, 0, 1, 2, 1));
        vt.push_back(V(0, 0, K_S, 3, 2, 2, 0, 1, 0, 1, 2, 1));
        vt.push_back(V(0, 1, K_S, 3, 2, 2, 0, 1, 1, 1, 2, 1));
        vt.push_back(V(0, 1, K_D, 3, 2, 2, 1, 1, 1, 1, 2, 1));
        vt.push_back(V(0, 1, K_S, 3, 2, 2, 1, 1, 0, 0, 3, 2));

        foreach (vt[i]) begin
            apply(vt[i].r, vt[i].t, vt[i].k);
            chk("t_page", i, pg[0], vt[i].pg);
            chk("t_hands", i, hd[0], vt[i].h);
            chk("t_s00", i, st[0][3:0], vt[i].s00);
            chk("t_cur_row", i, crw[0], vt[i].cr);
            chk("t_cur_col", i, ccl[0], vt[i].cc);
            chk("t_selecting", i, slg[0], vt[i].sl);
            chk("t_player", i, ply[0], vt[i].pl);
            chk("t_predict", i, prd[0], vt[i].pr);
            chk("t_move_cnt", i, mcn[0], vt[i].mc);
            apply(1'b0, 1'b1, K_0);
        end

        // Modulus-two copy: player 0 wins by zeroing both of its hands
        apply(1'b1, 1'b1, K_0);
        press(K_U); press(K_U);
        press(K_S); press(K_D); press(K_S);
        chk("m2_s00", 1, st[1][3:0], 0);
        chk("m2_p1", 1, ply[1], 1);
        press(K_R); press(K_S); press(K_U); press(K_S);
        chk("m2_s11", 1, st[1][27:24], 0);
        chk("m2_p0", 1, ply[1], 0);
        press(K_S); press(K_D); press(K_L); press(K_S);
        chk("m2_win", 1, ge[1], 1);
        chk("m2_s01", 1, st[1][7:4], 0);
        press(K_S);
        chk("m2_main", 1, pg[1], 0);

        // Modulus-two copy: zero-valued target is an illegal move
        apply(1'b1, 1'b0, K_0);
        press(K_U); press(K_U);
        press(K_S); press(K_D); press(K_S);
        press(K_S); press(K_U); press(K_S);
        chk("m2_mc2", 1, mcn[1], 2);
        chk("m2_s10", 1, st[1][23:20], 1);
        press(K_S); press(K_D); press(K_S);
        chk("ill_player", 1, ply[1], 0);
        chk("ill_mcnt", 1, mcn[1], 2);
        chk("ill_sel", 1, slg[1], 0);
        chk("ill_s00", 1, st[1][3:0], 0);

        // Held key yields one event; tick-less edges are ignored
        apply(1'b1, 1'b1, K_0);
        for (int i = 0; i < 10; i++) apply(1'b0, 1'b1, K_U);
        chk("hold_page", 0, pg[0], 2);
        apply(1'b0, 1'b1, K_0);
        apply(1'b0, 1'b0, K_D);
        apply(1'b0, 1'b0, K_0);
        chk("notick_page", 0, pg[0], 2);
        apply(1'b1, 1'b1, K_U);
        chk("rst_page", 0, pg[0], 0);
        apply(1'b0, 1'b1, K_U);
        chk("held_rst_page", 0, pg[0], 2);
        apply(1'b0, 1'b1, K_U);
        chk("held_rst_once", 0, pg[0], 2);

        for (int i = 0; i < 4000; i++) begin
            logic [4:0] kk;
            bit r, t;
            r = ($urandom_range(0, 599) == 0);
            t = ($urandom_range(0, 3) != 0);
            kk = 5'($urandom) & 5'($urandom);
            apply(r, t, kk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/chopsticks_ctrl.md
CHOPSTICKS_CTRL -- requirements
Module: chopsticks_ctrl

Interface
REQ-001 Parameter MAX_HANDS, default 5: maximum hands per player (2..8).
REQ-002 Parameter MIN_HANDS, default 2: minimum selectable hands per player (2..MAX_HANDS).
REQ-003 Parameter MOD, default 10: digit modulus (2..16); hand values are 4-bit, range 0..MOD-1.
REQ-004 Parameter DRAW_LIMIT, default 2: consecutive zero-source moves that end the game as a draw (1..7).
REQ-005 Localparam CW = clog2(MAX_HANDS): column index width.
REQ-006 Port clk, input, 1: sole clock.
REQ-007 Port rst, input, 1: reset, synchronous to clk, active-high.
REQ-008 Port tick, input, 1: key sample enable; all key processing occurs only on cycles with tick=1.
REQ-009 Port key_up, key_left, key_right, key_down, key_space, inputs, 1 each: decoded key levels, already synchronous to clk.
REQ-010 Port page, output, 2: 0=MAIN, 1=HELP, 2=CONFIG, 3=GAME.
REQ-011 Port hands, output, CW+1: active hands per player.
REQ-012 Port status, output, 8*MAX_HANDS: hand (row r, column c) at bits [(r*MAX_HANDS+c)*4 +: 4]; row 0 = player 0.
REQ-013 Port cur_row / cur_col, outputs, 1 / CW: cursor position.
REQ-014 Port sel_row / sel_col, outputs, 1 / CW: first-selected hand.
REQ-015 Port selecting, output, 1: first hand captured, awaiting second.
REQ-016 Port cur_player, output, 1: player to move.
REQ-017 Port predict, output, 4: combinational (value[cursor] + value[selected]) mod MOD.
REQ-018 Port game_end, output, 2: 0=running, 1=player 0 wins, 2=player 1 wins, 3=draw.
REQ-019 Port move_cnt, output, 8: legal moves in current game, saturating at 255.

Function
REQ-020 Key event = key level 1 and previous sampled level 0; previous levels update only when tick=1; a held key yields one event.
REQ-021 At most one event per tick, priority up > left > right > down > space; lower-priority events that tick are discarded.
REQ-022 Page FSM: MAIN-up->CONFIG, MAIN-down->HELP, HELP-down->MAIN, CONFIG-down->MAIN, CONFIG-up->GAME; all other keys ignored on MAIN/HELP.
REQ-023 CONFIG left: hands-1 saturating at MIN_HANDS; right: hands+1 saturating at MAX_HANDS; change visible next cycle.
REQ-024 Entering GAME: all 2*MAX_HANDS values =1, cursor (0,0), selected (0,0), selecting=0, cur_player=0, game_end=0, move_cnt=0, zero-run counter=0.
REQ-025 GAME up or down: toggle cur_row; column unchanged.
REQ-026 GAME left: cur_col-1, wrapping 0 -> hands-1; right: cur_col+1, wrapping hands-1 -> 0.
REQ-027 GAME space with game_end!=0: page -> MAIN, no other state change.
REQ-028 GAME space with selecting=0: selected <= cursor, selecting <= 1.
REQ-029 GAME space with selecting=1 and sel_row==cur_row: cancel; selecting <= 0, nothing else changes.
REQ-030 Otherwise target = the one of {selected, cursor} in row cur_player; source = the other.
REQ-031 Target value 0: illegal; selecting <= 0, status, cur_player, move_cnt unchanged.
REQ-032 Legal move: target <= (target+source) mod MOD via 5-bit sum, minus MOD if >= MOD; cur_player toggles; move_cnt increments; selecting <= 0.
REQ-033 Zero-run counter: increments on legal move with source=0 (saturating at DRAW_LIMIT), clears on legal move with source!=0.
REQ-034 game_end, evaluated on post-move values in the same update: all active row-0 hands zero -> 1; else all active row-1 hands zero -> 2; else zero-run==DRAW_LIMIT -> 3.
REQ-035 Inactive columns (>= hands) never affect win detection or cursor.
REQ-036 With game_end!=0, cursor movement still allowed; moves ignored.
REQ-037 predict is purely combinational from current status, cursor and selected registers.

Reset
REQ-038 rst=1 on a clk edge: page=0, hands=MIN_HANDS, status all 1, cursor/selected (0,0), selecting=0, cur_player=0, game_end=0, move_cnt=0, zero-run=0, previous key levels=0.
REQ-039 rst overrides tick and keys; reset mid-game discards the game; a key held through reset release produces one event on the first tick.

Verification
REQ-040 Reset, tick+up -> page=2; left -> hands=2; right x5 -> hands=5 (saturates).
REQ-041 hands=2, GAME: space at (0,0), down, space -> status(0,0)=2, cur_player=1, move_cnt=1, predict before second space =2.
REQ-042 Space (0,0), right, space -> cancel: selecting=0, status unchanged, cur_player=0.
REQ-043 MOD=2, hands=2: P0 (0,0)+(1,0) -> (0,0)=0; P1 (1,1)+(0,1) -> 0; P0 (0,1)+(1,0) -> row 0 zero, game_end=1; next space -> page=0.
REQ-044 MOD=2: target (0,0)=0 selected by P0 -> illegal, cur_player stays 0, move_cnt unchanged.
REQ-045 key_up held high for 10 ticks on MAIN -> exactly one transition; event without tick -> ignored.
